// File: rtl/dma_arbiter.sv
// Four-requester round-robin DMA arbiter with one outstanding memory transfer.
// Optional burst lock (owner kept for up to 8 transfers) under DMA_ARB_BURST_LOCK_EN.
module dma_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  rnw,
  input  logic [87:0] addr,
  input  logic [31:0] wd,
  output logic [3:0]  ack,
  output logic [3:0]  dend,
  output logic [7:0]  rd,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        mem_req,
  output logic [21:0] mem_addr,
  output logic        mem_rnw,
  output logic [7:0]  mem_wd,
  input  logic        mem_ack,
  input  logic        mem_end,
  input  logic [7:0]  mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t      state_q;
  logic [1:0]  owner_q;
  logic        mem_req_q;
  logic [21:0] addr_q;
  logic        rnw_q;
  logic [7:0]  wd_q;
  logic [7:0]  rd_q;
  logic [3:0]  dend_q;

  logic [1:0]  rr_idx;
  logic        rr_hit;
  logic [1:0]  cand;
  logic [1:0]  win;

  // Search starts one past the last owner, so the last owner ranks lowest.
  always_comb begin
    rr_idx = owner_q;
    rr_hit = 1'b0;
    cand   = owner_q;
    for (int k = 1; k <= 4; k++) begin
      cand = owner_q + k[1:0];
      if (!rr_hit && req[cand]) begin
        rr_idx = cand;
        rr_hit = 1'b1;
      end
    end
  end

`ifdef DMA_ARB_BURST_LOCK_EN
  logic [2:0] bcnt_q;
  logic       lock;

  assign lock = req[owner_q] && (bcnt_q != 3'd7);
  assign win  = lock ? owner_q : rr_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= 3'd0;
    end else if (state_q == IDLE && |req) begin
      bcnt_q <= lock ? bcnt_q + 3'd1 : 3'd0;
    end
  end
`else
  assign win = rr_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 2'd3;
      mem_req_q <= 1'b0;
      addr_q    <= 22'd0;
      rnw_q     <= 1'b1;
      wd_q      <= 8'd0;
      rd_q      <= 8'd0;
      dend_q    <= 4'd0;
    end else begin
      dend_q <= 4'd0;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q   <= win;
            addr_q    <= addr[22*win +: 22];
            rnw_q     <= rnw[win];
            wd_q      <= wd[8*win +: 8];
            mem_req_q <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (mem_end) begin
              if (rnw_q) rd_q <= mem_rd;
              dend_q  <= 4'b0001 << owner_q;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_end) begin
            if (rnw_q) rd_q <= mem_rd;
            dend_q  <= 4'b0001 << owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack      = (state_q == ISSUE && mem_ack && !rst) ?
                    (4'b0001 << owner_q) : 4'd0;
  assign dend     = dend_q;
  assign rd       = rd_q;
  assign owner    = owner_q;
  assign busy     = (state_q != IDLE);
  assign mem_req  = mem_req_q;
  assign mem_addr = addr_q;
  assign mem_rnw  = rnw_q;
  assign mem_wd   = wd_q;

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: req  in  4  per-requester DMA request, bit i = requester i.
REQ-004 SHALL have port: rnw  in  4  per-requester direction, 1 = read, 0 = write.
REQ-005 SHALL have port: addr  in  88  requester i address at [22i+21:22i].
REQ-006 SHALL have port: wd  in  32  requester i write data at [8i+7:8i].
REQ-007 SHALL have port: ack  out  4  transfer-accepted strobe to owner; requester advances its address on req&ack.
REQ-008 SHALL have port: dend  out  4  transfer-complete strobe to owner.
REQ-009 SHALL have port: rd  out  8  read data, valid when dend pulses for a read.
REQ-010 SHALL have port: owner  out  2  index of current or last granted requester.
REQ-011 SHALL have port: busy  out  1  high in any state except IDLE.
REQ-012 SHALL have ports: mem_req out 1, mem_addr out 22, mem_rnw out 1, mem_wd out 8: downstream memory request, all registered.
REQ-013 SHALL have ports: mem_ack in 1 (request taken), mem_end in 1 (cycle done), mem_rd in 8 (read data valid with mem_end).

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT; one transfer outstanding at most.
REQ-015 IDLE: when any req bit high, SHALL select winner by round-robin search starting at (owner+1) mod 4, load owner, mem_addr, mem_rnw, mem_wd from winner, set mem_req=1, go ISSUE next cycle.
REQ-016 ISSUE: mem_req and mem_* fields SHALL stay stable until mem_ack; ack[owner] = (state==ISSUE)&mem_ack, combinational, exactly one cycle; mem_req drops the cycle after; go WAIT.
REQ-017 WAIT: on mem_end SHALL latch rd<=mem_rd when mem_rnw=1 (rd unchanged on writes), pulse dend[owner] for one cycle on the next edge, return IDLE.
REQ-018 mem_ack and mem_end both high in ISSUE SHALL complete the transfer: ack and dend both produced, go IDLE, WAIT skipped.
REQ-019 Requester dropping req after selection SHALL NOT abort; transfer completes normally.
REQ-020 Minimum spacing: a new winner is selected no earlier than the cycle dend is asserted (one IDLE cycle between transfers).
REQ-021 No ack or dend bit other than owner's SHALL ever assert; at most one bit of each set per cycle.
REQ-022 mem_ack/mem_end outside ISSUE/WAIT SHALL be ignored.

Reset
REQ-023 rst high at a clock edge SHALL force: state IDLE, owner=2'd3 (so requester 0 wins first), mem_req=0, mem_rnw=1, mem_addr=0, mem_wd=0, rd=0, dend=0, busy=0, burst counter=0.
REQ-024 Reset mid-transfer SHALL drop the transfer without issuing ack or dend; the memory side is reset by the same rst.

Configuration
REQ-025 Macro DMA_ARB_BURST_LOCK_EN defined: in IDLE, if req[owner] is high and burst counter<7, owner SHALL be re-selected and counter incremented; otherwise normal round-robin and counter cleared; counter clears whenever a different requester wins.
REQ-026 Macro DMA_ARB_BURST_LOCK_EN undefined: pure round-robin each transfer, no burst counter logic synthesised.

Verification
REQ-027 Single: req=0001, rnw=0, addr0=22'h012345, wd0=8'hA5 -> mem_addr=012345, mem_wd=A5, ack=0001 with mem_ack, dend=0001 one cycle after mem_end.
REQ-028 Read: req=0100, rnw=0100, mem_rd=8'h3C on mem_end -> rd=3C, dend=0100, owner=2.
REQ-029 Fairness (lock off): req=1111 held, 8 transfers -> owner sequence 0,1,2,3,0,1,2,3.
REQ-030 Burst lock on: req=0011 held, 20 transfers -> owner 0 x8, 1 x8, 0 x4.
REQ-031 Same-cycle mem_ack+mem_end in ISSUE -> ack and dend both pulse, busy low next cycle; rst asserted in WAIT -> no dend, all outputs at reset values next cycle.
